// File: rtl/narnet_job_sequencer.sv
// narnet_job_sequencer: buffers host samples in a FIFO and runs multi-step
// open-loop or closed-loop jobs on the NARNet core, returning each step's
// prediction over a valid/ready stream. Hung steps are recovered by a
// timeout that resets the core and flags err_timeout.
module narnet_job_sequencer #(
  parameter int FIFO_DEPTH = 16,
  parameter int HORIZON_W  = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  input  logic [7:0]           s_data,
  output logic                 s_ready,
  input  logic                 start,
  input  logic                 closed_loop,
  input  logic [HORIZON_W-1:0] horizon,
  output logic                 busy,
  output logic                 m_valid,
  output logic [7:0]           m_data,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic                 err_timeout,
  output logic                 core_rst,
  output logic                 core_enable,
  output logic [7:0]           core_x_in,
  output logic                 core_x_ready,
  input  logic [7:0]           core_y_out,
  input  logic                 core_out_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0]        FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]        CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0]        CNT_ONE   = CW'(1);
  localparam logic [AW-1:0]        PTR_ONE   = AW'(1);
  localparam logic [TW-1:0]        TMO_ZERO  = TW'(0);
  localparam logic [TW-1:0]        TMO_ONE   = TW'(1);
  localparam logic [TW-1:0]        TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [HORIZON_W-1:0] STEP_ZERO = HORIZON_W'(0);
  localparam logic [HORIZON_W-1:0] STEP_ONE  = HORIZON_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CRST  = 3'd1,
    S_FETCH = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_EMIT  = 3'd5,
    S_FLUSH = 3'd6
  } state_e;

  // Sample storage; occupancy is tracked by count_q, so data needs no reset.
  logic [7:0]           mem [FIFO_DEPTH];

  state_e               state_q,        state_d;
  logic [AW-1:0]        wr_ptr_q,       wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q,       rd_ptr_d;
  logic [CW-1:0]        count_q,        count_d;
  logic                 s_ready_q,      s_ready_d;
  logic                 busy_q,         busy_d;
  logic                 mode_q,         mode_d;
  logic [HORIZON_W-1:0] horizon_q,      horizon_d;
  logic [HORIZON_W-1:0] step_q,         step_d;
  logic [7:0]           x_hold_q,       x_hold_d;
  logic [7:0]           fb_q,           fb_d;
  logic [TW-1:0]        tmo_q,          tmo_d;
  logic                 flush_q,        flush_d;
  logic                 m_valid_q,      m_valid_d;
  logic [7:0]           m_data_q,       m_data_d;
  logic                 m_last_q,       m_last_d;
  logic                 err_q,          err_d;
  logic                 core_rst_q,     core_rst_d;
  logic                 core_enable_q,  core_enable_d;
  logic                 core_x_ready_q, core_x_ready_d;

  logic                 push_s;
  logic                 pop_s;

  // s_ready_q mirrors !full, so a full FIFO never accepts a push even on a pop cycle.
  assign push_s = s_valid & s_ready_q;

  // Next-state logic for the job FSM, the FIFO pointers and all registered outputs.
  always_comb begin
    state_d        = state_q;
    busy_d         = busy_q;
    mode_d         = mode_q;
    horizon_d      = horizon_q;
    step_d         = step_q;
    x_hold_d       = x_hold_q;
    fb_d           = fb_q;
    tmo_d          = tmo_q;
    flush_d        = flush_q;
    m_valid_d      = m_valid_q;
    m_data_d       = m_data_q;
    m_last_d       = m_last_q;
    err_d          = err_q;
    core_rst_d     = core_rst_q;
    core_enable_d  = core_enable_q;
    core_x_ready_d = core_x_ready_q;
    pop_s          = 1'b0;

    case (state_q)
      S_IDLE: begin
        core_rst_d    = 1'b0;
        core_enable_d = 1'b0;
        if (start && (horizon != STEP_ZERO)) begin
          mode_d        = closed_loop;
          horizon_d     = horizon;
          step_d        = STEP_ZERO;
          err_d         = 1'b0;
          busy_d        = 1'b1;
          core_rst_d    = 1'b1;
          core_enable_d = 1'b1;
          state_d       = S_CRST;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CRST: begin
        // One cycle of core reset clears the core's delay line for the new job.
        core_rst_d = 1'b0;
        state_d    = S_FETCH;
      end
      S_FETCH: begin
        if (mode_q && (step_q != STEP_ZERO)) begin
          x_hold_d       = fb_q;
          core_x_ready_d = 1'b1;
          state_d        = S_ISSUE;
        end else if (count_q != CNT_ZERO) begin
          pop_s          = 1'b1;
          x_hold_d       = mem[rd_ptr_q];
          core_x_ready_d = 1'b1;
          state_d        = S_ISSUE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_ISSUE: begin
        core_x_ready_d = 1'b0;
        tmo_d          = TMO_ZERO;
        state_d        = S_WAIT;
      end
      S_WAIT: begin
        if (core_out_ready) begin
          m_data_d  = core_y_out;
          fb_d      = core_y_out;
          m_valid_d = 1'b1;
          m_last_d  = (step_q == (horizon_q - STEP_ONE));
          state_d   = S_EMIT;
        end else if (tmo_q == TMO_LAST) begin
          core_rst_d = 1'b1;
          err_d      = 1'b1;
          busy_d     = 1'b0;
          flush_d    = 1'b0;
          state_d    = S_FLUSH;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      S_EMIT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          step_d    = step_q + STEP_ONE;
          if (m_last_q) begin
            busy_d        = 1'b0;
            core_enable_d = 1'b0;
            state_d       = S_IDLE;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_EMIT;
        end
      end
      S_FLUSH: begin
        // Core reset is held for two cycles to recover a hung core.
        if (flush_q) begin
          core_rst_d    = 1'b0;
          core_enable_d = 1'b0;
          flush_d       = 1'b0;
          state_d       = S_IDLE;
        end else begin
          flush_d = 1'b1;
        end
      end
      default: begin
        busy_d         = 1'b0;
        m_valid_d      = 1'b0;
        m_last_d       = 1'b0;
        core_rst_d     = 1'b0;
        core_enable_d  = 1'b0;
        core_x_ready_d = 1'b0;
        state_d        = S_IDLE;
      end
    endcase

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s && !pop_s) begin
      count_d = count_q + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
    s_ready_d = (count_d != FULL_CNT);
  end

  // FIFO data write; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem[wr_ptr_q] <= s_data;
    end
  end

  // State and output registers with synchronous reset; core reset is asserted during rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= {AW{1'b0}};
      rd_ptr_q       <= {AW{1'b0}};
      count_q        <= CNT_ZERO;
      s_ready_q      <= 1'b0;
      busy_q         <= 1'b0;
      mode_q         <= 1'b0;
      horizon_q      <= STEP_ZERO;
      step_q         <= STEP_ZERO;
      x_hold_q       <= 8'h00;
      fb_q           <= 8'h00;
      tmo_q          <= TMO_ZERO;
      flush_q        <= 1'b0;
      m_valid_q      <= 1'b0;
      m_data_q       <= 8'h00;
      m_last_q       <= 1'b0;
      err_q          <= 1'b0;
      core_rst_q     <= 1'b1;
      core_enable_q  <= 1'b0;
      core_x_ready_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      s_ready_q      <= s_ready_d;
      busy_q         <= busy_d;
      mode_q         <= mode_d;
      horizon_q      <= horizon_d;
      step_q         <= step_d;
      x_hold_q       <= x_hold_d;
      fb_q           <= fb_d;
      tmo_q          <= tmo_d;
      flush_q        <= flush_d;
      m_valid_q      <= m_valid_d;
      m_data_q       <= m_data_d;
      m_last_q       <= m_last_d;
      err_q          <= err_d;
      core_rst_q     <= core_rst_d;
      core_enable_q  <= core_enable_d;
      core_x_ready_q <= core_x_ready_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign busy         = busy_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_last       = m_last_q;
  assign err_timeout  = err_q;
  assign core_rst     = core_rst_q;
  assign core_enable  = core_enable_q;
  assign core_x_in    = x_hold_q;
  assign core_x_ready = core_x_ready_q;

endmodule

// File: tb/tb_narnet_job_sequencer.sv
// Self-checking bench for narnet_job_sequencer: a behavioural core model,
// scoreboard queues of expected core inputs and results, and one task per scenario.
module tb_narnet_job_sequencer;

  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready;
  logic       start = 1'b0;
  logic       closed_loop = 1'b0;
  logic [7:0] horizon = 8'h00;
  logic       busy;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_ready = 1'b1;
  logic       err_timeout;
  logic       core_rst;
  logic       core_enable;
  logic [7:0] core_x_in;
  logic       core_x_ready;
  logic [7:0] core_y_out = 8'h00;
  logic       core_out_ready = 1'b0;

  // Core model controls
  int         core_lat   = 20;
  logic [7:0] core_delta = 8'd1;
  logic       core_hang  = 1'b0;
  logic       pend       = 1'b0;
  int         lat_cnt    = 0;
  logic [7:0] y_pend     = 8'h00;

  // Scoreboard
  logic [7:0] exp_x_q[$];
  logic [8:0] exp_m_q[$];
  int checks    = 0;
  int errors    = 0;
  int issue_cnt = 0;
  int res_cnt   = 0;

  narnet_job_sequencer #(
    .FIFO_DEPTH(16),
    .HORIZON_W (8),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .start         (start),
    .closed_loop   (closed_loop),
    .horizon       (horizon),
    .busy          (busy),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_last        (m_last),
    .m_ready       (m_ready),
    .err_timeout   (err_timeout),
    .core_rst      (core_rst),
    .core_enable   (core_enable),
    .core_x_in     (core_x_in),
    .core_x_ready  (core_x_ready),
    .core_y_out    (core_y_out),
    .core_out_ready(core_out_ready)
  );

  always #5 clk = ~clk;

  // Core model: y = x + delta, core_out_ready pulsed core_lat cycles after x_ready.
  always @(negedge clk) begin
    core_out_ready = 1'b0;
    if (rst || core_rst) begin
      pend = 1'b0;
    end else if (pend) begin
      if (lat_cnt == 0) begin
        core_out_ready = 1'b1;
        core_y_out     = y_pend;
        pend           = 1'b0;
      end else begin
        lat_cnt = lat_cnt - 1;
      end
    end
    if (core_x_ready && !rst && !core_hang) begin
      pend    = 1'b1;
      lat_cnt = core_lat;
      y_pend  = core_x_in + core_delta;
    end
  end

  // Scoreboard monitor: every issue and every result handshake is popped and compared.
  always @(negedge clk) begin
    logic [7:0] ex;
    logic [8:0] em;
    if (!rst && core_x_ready) begin
      issue_cnt = issue_cnt + 1;
      checks = checks + 1;
      if (exp_x_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL issue_unexpected got x_in=%h want no issue", core_x_in);
      end else begin
        ex = exp_x_q.pop_front();
        if (core_x_in !== ex) begin
          errors = errors + 1;
          $display("FAIL core_x_in got %h want %h", core_x_in, ex);
        end
      end
    end
    if (!rst && m_valid && m_ready) begin
      res_cnt = res_cnt + 1;
      checks = checks + 1;
      if (exp_m_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL result_unexpected got data=%h last=%b want no result", m_data, m_last);
      end else begin
        em = exp_m_q.pop_front();
        if ({m_last, m_data} !== em) begin
          errors = errors + 1;
          $display("FAIL result got last=%b data=%h want last=%b data=%h",
                   m_last, m_data, em[8], em[7:0]);
        end
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_sample(input logic [7:0] d);
    int n = 0;
    while (s_ready !== 1'b1 && n < 100) begin
      cyc(1);
      n++;
    end
    s_valid = 1'b1;
    s_data  = d;
    cyc(1);
    s_valid = 1'b0;
  endtask

  task automatic start_job(input logic cl, input logic [7:0] h);
    start       = 1'b1;
    closed_loop = cl;
    horizon     = h;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      cyc(1);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle got busy=%b want 0 within %0d cycles", name, busy, budget);
    end
    cyc(4);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    checks++;
    if ({core_rst, busy, m_valid, s_ready, err_timeout, core_enable, core_x_ready} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_outputs got rst/busy/mv/srdy/err/en/xr=%b want 1000000",
               {core_rst, busy, m_valid, s_ready, err_timeout, core_enable, core_x_ready});
    end
    rst = 1'b0;
    cyc(1);
    checks++;
    if ({core_rst, s_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL reset_release got core_rst/s_ready/busy=%b want 010", {core_rst, s_ready, busy});
    end
  endtask

  task automatic test_open_loop();
    int ic0 = issue_cnt;
    core_delta = 8'd1;
    core_lat   = 20;
    m_ready    = 1'b1;
    push_sample(8'd3);
    push_sample(8'd7);
    push_sample(8'hFB);
    exp_x_q.push_back(8'd3);  exp_m_q.push_back({1'b0, 8'd4});
    exp_x_q.push_back(8'd7);  exp_m_q.push_back({1'b0, 8'd8});
    exp_x_q.push_back(8'hFB); exp_m_q.push_back({1'b1, 8'hFC});
    start_job(1'b0, 8'd3);
    wait_idle(500, "open_loop");
    checks++;
    if (issue_cnt - ic0 !== 3) begin
      errors++;
      $display("FAIL open_loop_issues got %0d want 3", issue_cnt - ic0);
    end
  endtask

  task automatic test_closed_loop();
    int ic0 = issue_cnt;
    core_delta = 8'd2;
    push_sample(8'd10);
    push_sample(8'd55);
    exp_x_q.push_back(8'd10); exp_m_q.push_back({1'b0, 8'd12});
    exp_x_q.push_back(8'd12); exp_m_q.push_back({1'b0, 8'd14});
    exp_x_q.push_back(8'd14); exp_m_q.push_back({1'b0, 8'd16});
    exp_x_q.push_back(8'd16); exp_m_q.push_back({1'b1, 8'd18});
    start_job(1'b1, 8'd4);
    wait_idle(500, "closed_loop");
    checks++;
    if (issue_cnt - ic0 !== 4) begin
      errors++;
      $display("FAIL closed_loop_issues got %0d want 4", issue_cnt - ic0);
    end
    // Only the seed was popped: 55 must still be the FIFO head.
    exp_x_q.push_back(8'd55); exp_m_q.push_back({1'b1, 8'd57});
    start_job(1'b0, 8'd1);
    wait_idle(200, "closed_loop_left");
  endtask

  task automatic test_backpressure();
    int n = 0;
    int ic0;
    int rc0 = res_cnt;
    logic [7:0] md;
    logic stable = 1'b1;
    core_delta = 8'd1;
    for (int i = 0; i < 16; i++) begin
      push_sample(8'h20 + 8'(i));
      exp_x_q.push_back(8'h20 + 8'(i));
      exp_m_q.push_back({(i == 15), 8'h21 + 8'(i)});
    end
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL fifo_full_s_ready got %b want 0", s_ready);
    end
    s_valid = 1'b1;
    s_data  = 8'h7F;
    cyc(1);
    s_valid = 1'b0;
    start_job(1'b0, 8'd16);
    while (!(m_valid === 1'b1 && res_cnt == rc0 + 2) && n < 500) begin
      cyc(1);
      n++;
    end
    m_ready = 1'b0;
    md  = m_data;
    ic0 = issue_cnt;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (m_valid !== 1'b1 || m_data !== md) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1 || md !== 8'h23) begin
      errors++;
      $display("FAIL hold_stable got stable=%b data=%h want 1 data=23", stable, md);
    end
    checks++;
    if (issue_cnt !== ic0) begin
      errors++;
      $display("FAIL hold_no_issue got %0d issues want %0d", issue_cnt, ic0);
    end
    m_ready = 1'b1;
    wait_idle(2000, "backpressure");
    // FIFO must be empty now: the 17th push was dropped.
    ic0 = issue_cnt;
    start_job(1'b0, 8'd1);
    cyc(30);
    checks++;
    if (issue_cnt !== ic0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL dropped_push got issues=%0d busy=%b want %0d busy=1", issue_cnt, busy, ic0);
    end
    exp_x_q.push_back(8'h11); exp_m_q.push_back({1'b1, 8'h12});
    push_sample(8'h11);
    wait_idle(200, "backpressure_tail");
  endtask

  task automatic test_starvation();
    int n = 0;
    int ic0 = issue_cnt;
    int rc0 = res_cnt;
    core_delta = 8'd2;
    push_sample(8'd5);
    exp_x_q.push_back(8'd5); exp_m_q.push_back({1'b0, 8'd7});
    exp_x_q.push_back(8'd9); exp_m_q.push_back({1'b1, 8'd11});
    start_job(1'b0, 8'd2);
    while (res_cnt != rc0 + 1 && n < 300) begin
      cyc(1);
      n++;
    end
    cyc(40);
    checks++;
    if (issue_cnt !== ic0 + 1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL starve_wait got issues=%0d busy=%b want %0d busy=1", issue_cnt - ic0, busy, 1);
    end
    push_sample(8'd9);
    wait_idle(300, "starvation");
  endtask

  task automatic test_timeout();
    int n = 0;
    core_hang  = 1'b1;
    core_delta = 8'd2;
    push_sample(8'h30);
    exp_x_q.push_back(8'h30);
    start_job(1'b0, 8'd1);
    while (core_x_ready !== 1'b1 && n < 100) begin
      cyc(1);
      n++;
    end
    n = 0;
    while (core_rst !== 1'b1 && n < 400) begin
      cyc(1);
      n++;
    end
    checks++;
    if (n !== TIMEOUT + 1) begin
      errors++;
      $display("FAIL timeout_cycles got %0d want %0d", n, TIMEOUT + 1);
    end
    checks++;
    if ({err_timeout, busy, m_valid} !== 3'b100) begin
      errors++;
      $display("FAIL timeout_flags got err/busy/mv=%b want 100", {err_timeout, busy, m_valid});
    end
    cyc(1);
    checks++;
    if (core_rst !== 1'b1) begin
      errors++;
      $display("FAIL flush_cycle2 got core_rst=%b want 1", core_rst);
    end
    cyc(1);
    checks++;
    if ({core_rst, core_enable, err_timeout, m_valid} !== 4'b0010) begin
      errors++;
      $display("FAIL flush_end got rst/en/err/mv=%b want 0010", {core_rst, core_enable, err_timeout, m_valid});
    end
    core_hang = 1'b0;
    push_sample(8'h01);
    exp_x_q.push_back(8'h01); exp_m_q.push_back({1'b1, 8'h03});
    start_job(1'b0, 8'd1);
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got %b want 0", err_timeout);
    end
    wait_idle(200, "timeout_recover");
  endtask

  task automatic test_ignored_starts();
    int ic0 = issue_cnt;
    start_job(1'b0, 8'd0);
    cyc(3);
    checks++;
    if (busy !== 1'b0 || core_enable !== 1'b0) begin
      errors++;
      $display("FAIL zero_horizon got busy=%b en=%b want 0 0", busy, core_enable);
    end
    core_delta = 8'd2;
    push_sample(8'h40);
    exp_x_q.push_back(8'h40); exp_m_q.push_back({1'b1, 8'h42});
    start_job(1'b0, 8'd1);
    cyc(2);
    start_job(1'b1, 8'd5);
    wait_idle(200, "busy_start");
    cyc(30);
    checks++;
    if (issue_cnt !== ic0 + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_ignored got issues=%0d busy=%b want 1 busy=0", issue_cnt - ic0, busy);
    end
  endtask

  task automatic test_reset_in_wait();
    int n = 0;
    int ic0;
    core_lat = 100;
    push_sample(8'h50);
    push_sample(8'h51);
    exp_x_q.push_back(8'h50);
    start_job(1'b0, 8'd1);
    while (core_x_ready !== 1'b1 && n < 100) begin
      cyc(1);
      n++;
    end
    cyc(5);
    rst = 1'b1;
    cyc(1);
    checks++;
    if ({core_rst, busy, m_valid, s_ready, err_timeout, core_enable, core_x_ready} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_in_wait got rst/busy/mv/srdy/err/en/xr=%b want 1000000",
               {core_rst, busy, m_valid, s_ready, err_timeout, core_enable, core_x_ready});
    end
    rst = 1'b0;
    core_lat = 20;
    cyc(1);
    ic0 = issue_cnt;
    start_job(1'b0, 8'd1);
    cyc(30);
    checks++;
    if (issue_cnt !== ic0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_fifo_empty got issues=%0d busy=%b want %0d busy=1", issue_cnt, busy, ic0);
    end
    exp_x_q.push_back(8'h60); exp_m_q.push_back({1'b1, 8'h62});
    push_sample(8'h60);
    wait_idle(200, "reset_recover");
  endtask

  initial begin
    test_reset();
    test_open_loop();
    test_closed_loop();
    test_backpressure();
    test_starvation();
    test_timeout();
    test_ignored_starts();
    test_reset_in_wait();
    checks++;
    if (exp_x_q.size() != 0 || exp_m_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got x=%0d m=%0d pending want 0 0", exp_x_q.size(), exp_m_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
